// File: rtl/mem_arbiter.sv
// Shares one external SRAM between the instruction-fetch port and the data port.
// Latency: ack (DONE) WAIT_CYC+2 cycles after the request is sampled in IDLE; one access per WAIT_CYC+3 cycles.
// Backpressure: requests are held levels; stall_if/stall_mem stay high until the matching ack pulse.
module mem_arbiter #(
    parameter int WAIT_CYC = 1,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(WAIT_CYC);

    state_t            state;
    logic [2:0]        cnt;
    logic              last_mem;   // 1 = data port owned the previous access
    logic              gnt_mem;    // owner of the access in flight
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              pick_mem;
    logic              in_access;
    logic              last_cyc;

    // Data port wins when it is alone, or on a tie when fetch owned the previous access
    always_comb begin
        pick_mem = mem_req & (~if_req | ~last_mem);
    end

    // Access sequencer: grant/latch in IDLE, count wait cycles, pulse the ack from DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            last_mem  <= 1'b0;
            gnt_mem   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        state    <= ACCESS;
                        cnt      <= 3'd0;
                        gnt_mem  <= pick_mem;
                        lat_we   <= pick_mem & mem_we;
                        lat_addr <= pick_mem ? mem_addr : if_addr;
                        if (pick_mem) begin
                            lat_wdata <= mem_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        cnt     <= 3'd0;
                        if_ack  <= ~gnt_mem;
                        mem_ack <= gnt_mem;
                        // Read data is captured only into the owning port's register
                        if (!lat_we) begin
                            if (gnt_mem) begin
                                mem_rdata <= sram_dq_i;
                            end else begin
                                if_rdata <= sram_dq_i;
                            end
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    if_ack   <= 1'b0;
                    mem_ack  <= 1'b0;
                    last_mem <= gnt_mem;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM pins decoded only from state/cnt and the latched request, so they cannot glitch
    always_comb begin
        in_access  = (state == ACCESS);
        last_cyc   = (cnt == CNT_LAST);
        sram_addr  = lat_addr;
        sram_dq_o  = lat_wdata;
        sram_ce_n  = ~in_access;
        sram_oe_n  = ~(in_access & ~lat_we);
        // Write strobe releases one cycle early so address/data hold past its rising edge
        sram_we_n  = ~(in_access & lat_we & ~last_cyc);
        sram_dq_oe = in_access & lat_we;
    end

    // Pipeline freezes while a port waits; releases in the ack cycle
    always_comb begin
        stall_if  = if_req & ~if_ack;
        stall_mem = mem_req & ~mem_ack;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYC=1 instance (a_*) and WAIT_CYC=3 instance (b_*).
// Each instance drives its own behavioural SRAM model.
// Expected values are hand-derived cycle counts and data words.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic        a_if_req, a_mem_req, a_mem_we;
    logic [15:0] a_if_addr, a_mem_addr, a_mem_wdata;
    logic [15:0] a_if_rdata, a_mem_rdata, a_sram_addr, a_dq_o, a_sram_dq_i;
    logic        a_if_ack, a_mem_ack, a_stall_if, a_stall_mem;
    logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n;

    logic        b_if_req, b_mem_req, b_mem_we;
    logic [15:0] b_if_addr, b_mem_addr, b_mem_wdata;
    logic [15:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_dq_o, b_sram_dq_i;
    logic        b_if_ack, b_mem_ack, b_stall_if, b_stall_mem;
    logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem3 [0:65535];
    logic        pl_we, pl_sel;
    logic [15:0] pl_addr, pl_dat;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.WAIT_CYC(1), .ADDR_W(16), .DATA_W(16)) u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem),
        .sram_addr(a_sram_addr), .sram_dq_o(a_dq_o), .sram_dq_oe(a_dq_oe), .sram_dq_i(a_sram_dq_i),
        .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n)
    );

    mem_arbiter #(.WAIT_CYC(3), .ADDR_W(16), .DATA_W(16)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .sram_addr(b_sram_addr), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe), .sram_dq_i(b_sram_dq_i),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM models
    always_comb a_sram_dq_i = (!a_ce_n && !a_oe_n) ? mem0[a_sram_addr] : 16'h0000;
    always_comb b_sram_dq_i = (!b_ce_n && !b_oe_n) ? mem3[b_sram_addr] : 16'h0000;

    // SRAM writes: bench preload port, or a DUT write strobe
    always @(posedge clk) begin
        if (pl_we && !pl_sel) mem0[pl_addr] <= pl_dat;
        else if (!a_ce_n && !a_we_n && a_dq_oe) mem0[a_sram_addr] <= a_dq_o;
        if (pl_we && pl_sel) mem3[pl_addr] <= pl_dat;
        else if (!b_ce_n && !b_we_n && b_dq_oe) mem3[b_sram_addr] <= b_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [15:0] addr, input logic [15:0] dat);
        pl_sel  = sel;
        pl_addr = addr;
        pl_dat  = dat;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    initial begin
        int we_low, acks, ack_at, mem_at, if_at, stall_bad, n, oe_low, first_at, last_at;
        logic [5:0] seq;

        rst = 1'b0;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_dat = '0;
        a_if_req = 0; a_mem_req = 0; a_mem_we = 0;
        a_if_addr = '0; a_mem_addr = '0; a_mem_wdata = '0;
        b_if_req = 0; b_mem_req = 0; b_mem_we = 0;
        b_if_addr = '0; b_mem_addr = '0; b_mem_wdata = '0;

        repeat (2) @(negedge clk);
        preload(1'b0, 16'h0004, 16'h4E01);
        preload(1'b0, 16'h0006, 16'h5A5A);
        preload(1'b0, 16'h0010, 16'h7777);
        preload(1'b1, 16'h8000, 16'h00FF);

        // Reset state
        check("rst_ce_n", a_ce_n, 1);
        check("rst_oe_n", a_oe_n, 1);
        check("rst_we_n", a_we_n, 1);
        check("rst_dq_oe", a_dq_oe, 0);
        check("rst_addr", a_sram_addr, 0);
        check("rst_dq_o", a_dq_o, 0);
        check("rst_if_rdata", a_if_rdata, 0);
        check("rst_mem_rdata", a_mem_rdata, 0);
        check("rst_acks", {a_if_ack, a_mem_ack}, 0);
        check("rst_b_ce_n", b_ce_n, 1);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, WAIT_CYC=1
        a_if_addr = 16'h0004;
        a_if_req  = 1'b1;
        @(negedge clk);
        check("f1_oe_n", a_oe_n, 0);
        check("f1_addr", a_sram_addr, 16'h0004);
        check("f1_stall_if", a_stall_if, 1);
        check("f1_if_ack", a_if_ack, 0);
        @(negedge clk);
        check("f2_oe_n", a_oe_n, 0);
        check("f2_if_ack", a_if_ack, 0);
        @(negedge clk);
        check("f3_if_ack", a_if_ack, 1);
        check("f3_oe_n", a_oe_n, 1);
        check("f3_stall_if", a_stall_if, 0);
        check("f3_if_rdata", a_if_rdata, 16'h4E01);
        check("f3_mem_rdata", a_mem_rdata, 0);
        check("f3_mem_ack", a_mem_ack, 0);
        a_if_req = 1'b0;
        @(negedge clk);
        check("f4_if_ack", a_if_ack, 0);
        check("f4_if_rdata", a_if_rdata, 16'h4E01);

        // Store 0x1234 to 0xBF00
        a_mem_addr = 16'hBF00; a_mem_wdata = 16'h1234; a_mem_we = 1'b1; a_mem_req = 1'b1;
        we_low = 0; acks = 0; ack_at = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!a_we_n) we_low++;
            if (c == 1) begin
                check("st1_we_n", a_we_n, 0);
                check("st1_oe_n", a_oe_n, 1);
                check("st1_dq_oe", a_dq_oe, 1);
            end
            if (c == 2) begin
                check("st2_we_n", a_we_n, 1);
                check("st2_ce_n", a_ce_n, 0);
                check("st2_addr", a_sram_addr, 16'hBF00);
                check("st2_dq_o", a_dq_o, 16'h1234);
                check("st2_dq_oe", a_dq_oe, 1);
            end
            if (a_mem_ack) begin
                acks++;
                ack_at = c;
                a_mem_req = 1'b0;
            end
        end
        check("st_we_low_cycles", we_low, 1);
        check("st_ack_count", acks, 1);
        check("st_ack_cycle", ack_at, 3);
        check("st_mem_contents", mem0[16'hBF00], 16'h1234);
        check("st_mem_rdata_kept", a_mem_rdata, 0);

        // Reset in the first ACCESS cycle of a write
        a_mem_addr = 16'h0010; a_mem_wdata = 16'hAAAA; a_mem_we = 1'b1; a_mem_req = 1'b1;
        @(negedge clk);
        check("rw_we_n_before", a_we_n, 0);
        #2 rst = 1'b0;
        #1;
        check("rw_we_n", a_we_n, 1);
        check("rw_dq_oe", a_dq_oe, 0);
        check("rw_ce_n", a_ce_n, 1);
        a_mem_req = 1'b0;
        a_mem_we  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_mem_ack) acks++;
        end
        check("rw_no_ack", acks, 0);
        check("rw_mem_untouched", mem0[16'h0010], 16'h7777);

        // Simultaneous requests after reset: data first, then fetch
        a_if_addr = 16'h0006; a_mem_addr = 16'hBF00; a_mem_we = 1'b0;
        a_if_req = 1'b1; a_mem_req = 1'b1;
        mem_at = 0; if_at = 0; stall_bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if_at == 0 && !a_if_ack && !a_stall_if) stall_bad++;
            if (a_mem_ack) begin
                mem_at = c;
                a_mem_req = 1'b0;
            end
            if (a_if_ack) begin
                if_at = c;
                check("sim_stall_if_at_ack", a_stall_if, 0);
                a_if_req = 1'b0;
            end
        end
        check("sim_mem_ack_cycle", mem_at, 3);
        check("sim_if_ack_cycle", if_at, 7);
        check("sim_stall_if_held", stall_bad, 0);
        check("sim_mem_rdata", a_mem_rdata, 16'h1234);
        check("sim_if_rdata", a_if_rdata, 16'h5A5A);

        // Continuous contention: grants alternate starting with data
        a_if_req = 1'b1; a_mem_req = 1'b1;
        n = 0; seq = '0; first_at = 0; last_at = 0;
        for (int c = 1; c <= 60 && n < 6; c++) begin
            @(negedge clk);
            if (a_mem_ack || a_if_ack) begin
                if (n == 0) first_at = c;
                last_at = c;
                seq[n] = a_mem_ack;
                n++;
                if (n == 6) begin
                    a_if_req = 1'b0;
                    a_mem_req = 1'b0;
                end
            end
        end
        check("cont_count", n, 6);
        check("cont_order", seq, 6'b010101);
        check("cont_span", last_at - first_at, 20);

        // WAIT_CYC=3 read, request dropped in the second ACCESS cycle
        b_mem_addr = 16'h8000; b_mem_we = 1'b0; b_mem_req = 1'b1;
        oe_low = 0; acks = 0; ack_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!b_oe_n) oe_low++;
            if (c == 1) check("w3_stall_mem", b_stall_mem, 1);
            if (b_mem_ack) begin
                acks++;
                ack_at = c;
            end
            if (c == 2) b_mem_req = 1'b0;
        end
        check("w3_access_cycles", oe_low, 4);
        check("w3_ack_cycle", ack_at, 5);
        check("w3_ack_count", acks, 1);
        check("w3_mem_rdata", b_mem_rdata, 16'h00FF);
        check("w3_if_rdata", b_if_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
